// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32I data memory: valid/ready request port, fixed-latency response,
// per-lane store/load with sign/zero extension, fault flagging and a post-reset zero-clear.
package dmem_ctrl_pkg;
  typedef enum logic [3:0] {
    LB  = 4'h0,
    LH  = 4'h1,
    LW  = 4'h2,
    LBU = 4'h4,
    LHU = 4'h5,
    SB  = 4'h8,
    SH  = 4'h9,
    SW  = 4'hA
  } operation_e;
endpackage

module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned INIT_CLEAR  = 1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  operation_e  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_fault_o,
  input  logic [31:0] debug_addr_i,
  output logic [31:0] debug_data_o
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_LIMIT  = 33'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e        state_q;
  logic [AW-1:0] clr_idx_q;
  logic          ready_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [READ_LAT-1:0]       vld_q;
  logic [READ_LAT-1:0]       fault_q;
  logic [READ_LAT-1:0][31:0] rdata_q;

  logic          accept;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic [31:0]   word;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          legal;
  logic          misaligned;
  logic          fault;
  logic [3:0]    be;
  logic [3:0]    wr_be;
  logic [31:0]   wdata_lane;
  logic [31:0]   load_val;
  logic [31:0]   rdata_new;
  logic          unused_dbg;

  assign accept       = req_valid_i & ready_q;
  assign widx         = req_addr_i[AW+1:2];
  assign lane         = req_addr_i[1:0];
  assign out_of_range = {1'b0, req_addr_i} >= BYTE_LIMIT;
  assign word         = mem_q[widx];
  assign byte_sel     = word[{lane, 3'b000} +: 8];
  assign half_sel     = lane[1] ? word[31:16] : word[15:0];
  assign unused_dbg   = ^debug_addr_i[31:AW];

  // Decode op into lane enables, extended load value and alignment fault
  always_comb begin
    legal      = 1'b1;
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata_lane = '0;
    load_val   = '0;
    case (req_op_i)
      LB:  load_val = {{24{byte_sel[7]}}, byte_sel};
      LBU: load_val = {24'b0, byte_sel};
      LH: begin
        misaligned = lane[0];
        load_val   = {{16{half_sel[15]}}, half_sel};
      end
      LHU: begin
        misaligned = lane[0];
        load_val   = {16'b0, half_sel};
      end
      LW: begin
        misaligned = lane != 2'b00;
        load_val   = word;
      end
      SB: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{req_wdata_i[7:0]}};
      end
      SH: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{req_wdata_i[15:0]}};
      end
      SW: begin
        misaligned = lane != 2'b00;
        be         = 4'b1111;
        wdata_lane = req_wdata_i;
      end
      default: legal = 1'b0;
    endcase
    fault     = legal & (misaligned | out_of_range);
    wr_be     = (accept && !fault) ? be : 4'b0000;
    rdata_new = (accept && !fault) ? load_val : 32'h0;
  end

  // Array: zero-clear during INIT, lane-masked stores in RUN
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      mem_q[clr_idx_q] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[widx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // Init/run control with registered ready
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          clr_idx_q <= clr_idx_q + AW'(1);
          if (clr_idx_q == LAST_WORD) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN:  ready_q <= 1'b1;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Response shift pipeline; stage 0 captures on the acceptance edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q   <= '0;
      fault_q <= '0;
      rdata_q <= '0;
    end else begin
      vld_q[0]   <= accept;
      fault_q[0] <= accept & fault;
      rdata_q[0] <= rdata_new;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        fault_q[i] <= fault_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = vld_q[READ_LAT-1];
  assign rsp_fault_o  = fault_q[READ_LAT-1];
  assign rsp_rdata_o  = rdata_q[READ_LAT-1];
  assign debug_data_o = mem_q[debug_addr_i[AW-1:0]];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-array reference model, queued expectations,
// independent monitor checking data, fault flag and response cycle.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned LAT   = 2;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  operation_e  req_op_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_fault_o;
  logic [31:0] debug_addr_i;
  logic [31:0] debug_data_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  exp_t m_e;
  logic [7:0] ref_mem [4*DEPTH];

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LAT(LAT), .INIT_CLEAR(1)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_fault_o(rsp_fault_o),
    .debug_addr_i(debug_addr_i), .debug_data_o(debug_data_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: memory as a flat byte array, accesses by size and alignment rules
  function automatic exp_t model_access(operation_e op, logic [31:0] addr, logic [31:0] wdata);
    exp_t        e;
    int unsigned size;
    bit          sext;
    bit          store;
    logic [31:0] val;
    e.cyc = 0; e.rdata = 32'h0; e.fault = 1'b0;
    sext = 1'b0; store = 1'b0; size = 0;
    case (op)
      LB:  begin size = 1; sext = 1'b1; end
      LBU: size = 1;
      LH:  begin size = 2; sext = 1'b1; end
      LHU: size = 2;
      LW:  size = 4;
      SB:  begin size = 1; store = 1'b1; end
      SH:  begin size = 2; store = 1'b1; end
      SW:  begin size = 4; store = 1'b1; end
      default: size = 0;
    endcase
    if (size == 0) return e;
    if ((addr % size) != 0 || 64'(addr) >= 64'(4 * DEPTH)) begin
      e.fault = 1'b1;
      return e;
    end
    if (store) begin
      for (int i = 0; i < int'(size); i++) ref_mem[addr + i] = wdata[8*i +: 8];
      return e;
    end
    val = 32'h0;
    for (int i = 0; i < int'(size); i++) val = val | (32'(ref_mem[addr + i]) << (8 * i));
    if (sext && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
    e.rdata = val;
    return e;
  endfunction

  function automatic logic [31:0] model_word(int unsigned w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response
  always @(negedge clk_i) begin
    if (rstn_i) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_rsp: no response, required at cycle %0d (now %0d)", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: rdata %h fault %b, required no response (cycle %0d)",
                   rsp_rdata_o, rsp_fault_o, cyc);
        end else begin
          m_e = exp_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(m_e.cyc));
          check("rsp_rdata", rsp_rdata_o, m_e.rdata);
          check("rsp_fault", 32'(rsp_fault_o), 32'(m_e.fault));
        end
      end
    end
  end

  task automatic check_debug();
    check("debug_data", debug_data_o, model_word(debug_addr_i % DEPTH));
  endtask

  task automatic drive(operation_e op, logic [31:0] addr, logic [31:0] wdata,
                       bit has_exp, logic [31:0] xr, bit xf);
    exp_t e;
    @(negedge clk_i);
    check_debug();
    req_valid_i  = 1'b1;
    req_op_i     = op;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    debug_addr_i = 32'($urandom_range(0, DEPTH - 1));
    if (req_ready_o) begin
      e = model_access(op, addr, wdata);
      if (has_exp) begin
        e.rdata = xr;
        e.fault = xf;
      end
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic dir(operation_e op, logic [31:0] addr, logic [31:0] wdata,
                     logic [31:0] xr, bit xf);
    drive(op, addr, wdata, 1'b1, xr, xf);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check_debug();
      req_valid_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i      = 1'b0;
    req_valid_i = 1'b0;
    exp_q.delete();
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_fault", 32'(rsp_fault_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  // Holds a request during the clear; ready must rise only after edge DEPTH
  task automatic init_steps(int steps);
    req_valid_i = 1'b1;
    req_op_i    = LW;
    req_addr_i  = 32'h0;
    for (int k = 1; k <= steps; k++) begin
      @(negedge clk_i);
      check("init_ready", 32'(req_ready_o), (k == int'(DEPTH)) ? 32'd1 : 32'd0);
    end
    req_valid_i = 1'b0;
    if (steps == int'(DEPTH)) foreach (ref_mem[i]) ref_mem[i] = 8'h00;
  endtask

  operation_e ops[8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    operation_e  op;
    logic [31:0] addr;
    int unsigned w, r, ln;

    rstn_i = 1'b0; req_valid_i = 1'b0; req_op_i = LB;
    req_addr_i = '0; req_wdata_i = '0; debug_addr_i = '0;

    do_reset();
    init_steps(DEPTH);
    do_reset();
    init_steps(8);
    do_reset();
    init_steps(DEPTH);

    dir(LW, 32'h3C, 0, 32'h0, 1'b0);
    dir(LW, 32'(4*DEPTH - 4), 0, 32'h0, 1'b0);
    dir(SW, 32'h100, 32'h1122_3344, 32'h0, 1'b0);
    dir(SB, 32'h102, 32'h0000_00AA, 32'h0, 1'b0);
    dir(LW, 32'h100, 0, 32'h11AA_3344, 1'b0);
    dir(SH, 32'h100, 32'h0000_BEEF, 32'h0, 1'b0);
    dir(LW, 32'h100, 0, 32'h11AA_BEEF, 1'b0);
    dir(SW, 32'h40, 32'h80FF_7F80, 32'h0, 1'b0);
    dir(LB, 32'h40, 0, 32'hFFFF_FF80, 1'b0);
    dir(LBU, 32'h40, 0, 32'h0000_0080, 1'b0);
    dir(LB, 32'h41, 0, 32'h0000_007F, 1'b0);
    dir(LH, 32'h42, 0, 32'hFFFF_80FF, 1'b0);
    dir(LHU, 32'h42, 0, 32'h0000_80FF, 1'b0);
    dir(LH, 32'h41, 0, 32'h0, 1'b1);
    dir(SW, 32'h102, 32'hDEAD_BEEF, 32'h0, 1'b1);
    dir(LW, 32'h100, 0, 32'h11AA_BEEF, 1'b0);
    dir(LW, 32'(4*DEPTH), 0, 32'h0, 1'b1);
    dir(SW, 32'(4*DEPTH), 32'hFFFF_FFFF, 32'h0, 1'b1);
    idle(1);
    dir(SW, 32'h20, 32'd5, 32'h0, 1'b0);
    dir(LW, 32'h20, 0, 32'd5, 1'b0);
    dir(operation_e'(4'd3), 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b0);
    dir(operation_e'(4'hF), 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b0);
    dir(LW, 32'h20, 0, 32'd5, 1'b0);
    idle(LAT + 2);

    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        w  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7);
        ln = $urandom_range(0, 3);
        r  = $urandom_range(0, 99);
        if (r < 5) begin
          op   = operation_e'(4'($urandom_range(11, 15)));
          addr = 32'(w * 4);
        end else begin
          op = ops[$urandom_range(0, 7)];
          if (op inside {LH, LHU, SH}) ln = ln & 2;
          if (op inside {LW, SW}) ln = 0;
          if (r < 10)      addr = 32'(4 * DEPTH + $urandom_range(0, 1023));
          else if (r < 12) addr = 32'hFFFF_FFFC;
          else if (r < 25) addr = 32'(w * 4 + $urandom_range(0, 3));
          else             addr = 32'(w * 4 + ln);
        end
        drive(op, addr, $urandom, 1'b0, 32'h0, 1'b0);
      end
    end
    idle(LAT + 3);

    // Reset with responses still in flight: they must vanish
    dir(SW, 32'h20, 32'd9, 32'h0, 1'b0);
    dir(LW, 32'h20, 0, 32'd9, 1'b0);
    do_reset();
    init_steps(DEPTH);
    dir(LW, 32'h20, 0, 32'h0, 1'b0);
    idle(LAT + 3);

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, byte-addressed data memory for the RV32I pipeline's MEM stage, with a valid/ready request port and a fixed-latency response. Loads and stores are resolved per byte lane from `addr[1:0]`, and loads are correctly sign- or zero-extended. Misaligned and out-of-range accesses are flagged as faults instead of corrupting memory. After every reset an init FSM zero-clears the array before the first request is accepted.

## Interface
- `DEPTH_WORDS`, 2048: number of 32-bit words; power of two, ≥ 4.
- `READ_LAT`, 1: response latency in cycles; legal range 1..3.
- `INIT_CLEAR`, 1: 1 = zero-clear the array after reset; 0 = skip the clear.
- `clk_i`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request.
- `req_op_i`  in  `operation_e`  LB, LH, LW, LBU, LHU, SB, SH or SW; any other value is a no-op.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data; low bytes are used for SB/SH.
- `rsp_valid_o`  out  1  response present; held for exactly one cycle.
- `rsp_rdata_o`  out  32  load result; 0 for stores, no-ops and faults.
- `rsp_fault_o`  out  1  misaligned or out-of-range access.
- `debug_addr_i`  in  32  word index for the debug read.
- `debug_data_o`  out  32  combinational read of `array[debug_addr_i]`, using its low `log2(DEPTH_WORDS)` bits.

## Operation
- **Address split:** word index = `addr[log2(DEPTH_WORDS)+1:2]`; lane = `addr[1:0]`.
- **Fault conditions:**
  - LH, LHU or SH with `addr[0]` = 1.
  - LW or SW with `addr[1:0]` ≠ 0.
  - `addr` ≥ 4·`DEPTH_WORDS`.
- **On a fault:** no array write, `rsp_rdata_o` = 0, `rsp_fault_o` = 1.
- **Stores:** write only the addressed lanes.
  - SB writes byte lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes `{addr[1],0}` and `{addr[1],1}` with `wdata[15:0]`.
  - SW writes all four lanes.
  - Untouched lanes keep their value.
- **Loads:**
  - Extract the byte or halfword from the addressed lane.
  - LB/LH sign-extend from bit 7/15 of the extracted field.
  - LBU/LHU zero-extend.
  - LW returns the whole word.
- **Responses:** every accepted request, including stores and no-ops, produces exactly one response.
- **FSM states:** INIT, RUN.
  - Reset → INIT if `INIT_CLEAR` = 1, otherwise → RUN.
  - INIT: a counter `clr_idx` starts at 0 and writes 0 to `array[clr_idx]` each cycle. After writing `DEPTH_WORDS`-1 the FSM goes to RUN.
  - RUN: `req_ready_o` = 1; the FSM stays in RUN until reset.
- **Acceptance:** a request is accepted on a rising edge where `req_valid_i` && `req_ready_o`. Requests presented while not ready are ignored and produce no response.

## Timing
- **Reset values:** `req_ready_o` = 0, `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `rsp_fault_o` = 0. All response pipeline stages are cleared; FSM is in INIT (or RUN if `INIT_CLEAR` = 0, still with `req_ready_o` = 0 during reset).
- **Init with `INIT_CLEAR` = 1:** the first edge after reset release clears word 0, and edge n clears word n-1. `req_ready_o` rises after edge `DEPTH_WORDS`.
- **Init with `INIT_CLEAR` = 0:** `req_ready_o` rises after the first edge following reset release.
- **Store commit:** a store commits to the array on its acceptance edge.
- **Load sampling:** a load samples the array on its acceptance edge. It therefore sees every store accepted on earlier edges, and a store followed by a load to the same word on the next cycle needs no forwarding.
- **Response latency:** for a request accepted on edge k, `rsp_valid_o`, `rsp_rdata_o` and `rsp_fault_o` are driven after edge k+`READ_LAT`-1. They are valid for one cycle and then drop unless the next request was accepted on edge k+1.
- **Throughput:** back-to-back requests give one response per cycle, in order.
- **No backpressure:** there is no response-side backpressure; the consumer must always accept.
- **Reset mid-operation:**
  - Outputs clear immediately.
  - In-flight responses are discarded.
  - A reset during INIT restarts the clear from word 0.
  - Array contents are otherwise undefined until cleared.
- **Debug port:** `debug_data_o` is purely combinational and reflects stores from the previous edge onward.

## Test plan
- **Init / reset:** `DEPTH_WORDS` = 16, `INIT_CLEAR` = 1; release reset → `req_ready_o` = 0 for 16 edges then 1; an LW to 0x3C returns 0. Assert reset at clear step 8 → the clear restarts at word 0 and takes 16 edges again.
- **Lane stores:** SW 0x100 = 0x11223344, then SB 0x102 = 0xAA → LW 0x100 = 0x11AA3344. SH 0x100 = 0xBEEF → 0x11AABEEF.
- **Sign / zero extension:** with word 0x80FF7F80 at 0x40:
  - LB 0x40 = 0xFFFFFF80; LBU 0x40 = 0x00000080; LB 0x41 = 0x0000007F.
  - LH 0x42 = 0xFFFF80FF; LHU 0x42 = 0x000080FF.
- **Faults:** each of the following returns `rsp_fault_o` = 1 and `rsp_rdata_o` = 0, and the array is unchanged:
  - LH 0x41, SW 0x102 = 0xDEADBEEF (word at 0x100 unchanged).
  - LW 4·`DEPTH_WORDS`.
- **Latency / throughput:** for `READ_LAT` ∈ {1,2,3}, issue SW 0x20 = 5 then LW 0x20 back-to-back → two consecutive responses; the load returns 5, arriving `READ_LAT`-1 cycles after its acceptance edge.
- **Not-ready / no-op:** `req_valid_i` held during INIT → no responses; an accepted illegal `req_op_i` → one response with `rsp_rdata_o` = 0, `rsp_fault_o` = 0, and no write.
